// File: rtl/mod_addsub_seq.sv
// Limb-serial modular adder/subtractor: out = (A+B) mod M or (A-B) mod M,
// one LIMB per cycle, with valid/ready handshakes and an operand range check.
module mod_addsub_seq #(
  parameter int WIDTH = 256,
  parameter int LIMB  = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic [WIDTH-1:0] opM,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_err,
  output logic             busy
);

  localparam int NLIMB = WIDTH / LIMB;
  localparam int CW    = (NLIMB > 1) ? $clog2(NLIMB) : 1;
  localparam logic [CW-1:0] LAST = CW'(NLIMB - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, m_q, m_d;
  logic             mode_q, mode_d;
  // c1: add carry / sub borrow of the primary chain; c2: chain of the M-corrected value
  logic             c1_q, c1_d, c2_q, c2_d;
  logic             ba_q, ba_d, bb_q, bb_d, mnz_q, mnz_d;
  logic [WIDTH-1:0] p_q, p_d, t_q, t_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_err_q, out_err_d;
  logic             out_valid_q, out_valid_d;

  logic [LIMB-1:0]  a_l, b_l, m_l;
  logic [LIMB:0]    sum1, sum2, ra, rb;
  logic             c1_n, c2_n, ba_n, bb_n, mnz_n, sel_t;
  int               lsel;

  always_comb begin
    lsel = int'(cnt_q) * LIMB;
    a_l  = a_q[lsel +: LIMB];
    b_l  = b_q[lsel +: LIMB];
    m_l  = m_q[lsel +: LIMB];

    if (mode_q) begin
      sum1 = {1'b0, a_l} - {1'b0, b_l} - (LIMB+1)'(c1_q);
      sum2 = {1'b0, sum1[LIMB-1:0]} + {1'b0, m_l} + (LIMB+1)'(c2_q);
    end else begin
      sum1 = {1'b0, a_l} + {1'b0, b_l} + (LIMB+1)'(c1_q);
      sum2 = {1'b0, sum1[LIMB-1:0]} - {1'b0, m_l} - (LIMB+1)'(c2_q);
    end
    ra = {1'b0, a_l} - {1'b0, m_l} - (LIMB+1)'(ba_q);
    rb = {1'b0, b_l} - {1'b0, m_l} - (LIMB+1)'(bb_q);

    c1_n  = sum1[LIMB];
    c2_n  = sum2[LIMB];
    ba_n  = ra[LIMB];
    bb_n  = rb[LIMB];
    mnz_n = mnz_q | (|m_l);
    // Sub: borrow out means A<B, so add M back. Add: take s-M when s>=M.
    sel_t = mode_q ? c1_n : (c1_n | ~c2_n);
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    m_d         = m_q;
    mode_d      = mode_q;
    c1_d        = c1_q;
    c2_d        = c2_q;
    ba_d        = ba_q;
    bb_d        = bb_q;
    mnz_d       = mnz_q;
    p_d         = p_q;
    t_d         = t_q;
    out_data_d  = out_data_q;
    out_err_d   = out_err_q;
    out_valid_d = out_valid_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = opA;
          b_d     = opB;
          m_d     = opM;
          mode_d  = in_mode;
          c1_d    = 1'b0;
          c2_d    = 1'b0;
          ba_d    = 1'b0;
          bb_d    = 1'b0;
          mnz_d   = 1'b0;
          cnt_d   = '0;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        c1_d  = c1_n;
        c2_d  = c2_n;
        ba_d  = ba_n;
        bb_d  = bb_n;
        mnz_d = mnz_n;
        p_d[lsel +: LIMB] = sum1[LIMB-1:0];
        t_d[lsel +: LIMB] = sum2[LIMB-1:0];
        if (cnt_q == LAST) begin
          out_data_d  = sel_t ? t_d : p_d;
          out_err_d   = ~ba_n | ~bb_n | ~mnz_n;
          out_valid_d = 1'b1;
          cnt_d       = '0;
          state_d     = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      m_q         <= '0;
      mode_q      <= 1'b0;
      c1_q        <= 1'b0;
      c2_q        <= 1'b0;
      ba_q        <= 1'b0;
      bb_q        <= 1'b0;
      mnz_q       <= 1'b0;
      p_q         <= '0;
      t_q         <= '0;
      out_data_q  <= '0;
      out_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      m_q         <= m_d;
      mode_q      <= mode_d;
      c1_q        <= c1_d;
      c2_q        <= c2_d;
      ba_q        <= ba_d;
      bb_q        <= bb_d;
      mnz_q       <= mnz_d;
      p_q         <= p_d;
      t_q         <= t_d;
      out_data_q  <= out_data_d;
      out_err_q   <= out_err_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_err   = out_err_q;

endmodule
